// File: rtl/ball_ctrl.sv
// ball_ctrl: frame-rate ball motion, paddle collision and rally scoring.
// All game state advances once per frame, on the falling edge of vsync.
module ball_ctrl #(
    parameter int SIZE      = 8,
    parameter int SPD_X     = 8,
    parameter int SPD_Y     = 4,
    parameter int P1_X      = 40,
    parameter int P2_X      = 600,
    parameter int PAD_W     = 8,
    parameter int PAD_H     = 50,
    parameter int H_ACT     = 640,
    parameter int V_ACT     = 480,
    parameter int WIN_SCORE = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       p1_srv,
    input  logic       p2_srv,
    input  logic [8:0] p1_y,
    input  logic [8:0] p2_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       point,
    output logic       game_over
);

    typedef enum logic [1:0] {
        SERVE_P1,
        SERVE_P2,
        PLAY,
        GAME_OVER
    } state_t;

    localparam logic signed [11:0] FACE1 = 12'(P1_X + PAD_W);
    localparam logic signed [11:0] FACE2 = 12'(P2_X - SIZE);
    localparam logic signed [11:0] Y_MAX = 12'(V_ACT - SIZE);
    localparam logic signed [11:0] PARK_OFS = 12'(PAD_H / 2 - SIZE / 2);
    localparam logic signed [11:0] S_SIZE = 12'(SIZE);
    localparam logic signed [11:0] S_SPD_X = 12'(SPD_X);
    localparam logic signed [11:0] S_SPD_Y = 12'(SPD_Y);
    localparam logic signed [11:0] S_P1_X = 12'(P1_X);
    localparam logic signed [11:0] S_P2_X = 12'(P2_X);
    localparam logic signed [11:0] S_PAD_W = 12'(PAD_W);
    localparam logic signed [11:0] S_PAD_H = 12'(PAD_H);
    localparam logic signed [11:0] S_H_ACT = 12'(H_ACT);
    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t state, state_nxt;

    logic vsync_prev;
    logic tick;
    logic dx, dy;
    logic dx_nxt, dy_nxt;
    logic [3:0] sc1_nxt, sc2_nxt;
    logic point_nxt, over_nxt;
    logic signed [11:0] bx, by, py1, py2;
    logic signed [11:0] srv_y, park_y;
    logic signed [11:0] step_x, step_y;
    logic signed [11:0] x_nxt, y_nxt;
    logic hit1, hit2;
    logic miss_l, miss_r;
    logic win_l, win_r;
    logic unused_bits;

    assign tick = vsync_prev & ~vsync;

    assign bx  = {2'b00, ball_x};
    assign by  = {3'b000, ball_y};
    assign py1 = {3'b000, p1_y};
    assign py2 = {3'b000, p2_y};

    // A paddle only counts when the ball is travelling toward it.
    assign hit1 = dx
               && (bx < S_P1_X + S_PAD_W)
               && (bx + S_SIZE > S_P1_X)
               && (by < py1 + S_PAD_H)
               && (by + S_SIZE > py1);
    assign hit2 = !dx
               && (bx < S_P2_X + S_PAD_W)
               && (bx + S_SIZE > S_P2_X)
               && (by < py2 + S_PAD_H)
               && (by + S_SIZE > py2);

    assign step_x = dx ? bx - S_SPD_X : bx + S_SPD_X;
    assign step_y = dy ? by - S_SPD_Y : by + S_SPD_Y;

    assign miss_l = dx && !hit1 && (bx < S_SPD_X);
    assign miss_r = !dx && !hit2
                 && (bx + S_SIZE + S_SPD_X > S_H_ACT);

    assign win_l = (score_p2 + 4'd1) == WIN;
    assign win_r = (score_p1 + 4'd1) == WIN;

    assign srv_y = (state == SERVE_P1 ? py1 : py2) + PARK_OFS;

    always_comb begin
        park_y = srv_y;
        if (srv_y < 0) begin
            park_y = '0;
        end else if (srv_y > Y_MAX) begin
            park_y = Y_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SERVE_P2;
        end else if (tick) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SERVE_P1: begin
                if (p1_srv) state_nxt = PLAY;
            end
            SERVE_P2: begin
                if (p2_srv) state_nxt = PLAY;
            end
            PLAY: begin
                if (miss_l) begin
                    state_nxt = win_l ? GAME_OVER : SERVE_P1;
                end else if (miss_r) begin
                    state_nxt = win_r ? GAME_OVER : SERVE_P2;
                end
            end
            GAME_OVER: begin
                if (p1_srv | p2_srv) state_nxt = SERVE_P2;
            end
        endcase
    end

    always_comb begin
        x_nxt     = bx;
        y_nxt     = by;
        dx_nxt    = dx;
        dy_nxt    = dy;
        sc1_nxt   = score_p1;
        sc2_nxt   = score_p2;
        point_nxt = 1'b0;
        over_nxt  = (state_nxt == GAME_OVER);
        unique case (state)
            SERVE_P1: begin
                x_nxt = FACE1;
                y_nxt = park_y;
                if (p1_srv) begin
                    dx_nxt = 1'b0;
                    dy_nxt = 1'b0;
                end
            end
            SERVE_P2: begin
                x_nxt = FACE2;
                y_nxt = park_y;
                if (p2_srv) begin
                    dx_nxt = 1'b1;
                    dy_nxt = 1'b0;
                end
            end
            PLAY: begin
                if (hit1) begin
                    x_nxt  = FACE1;
                    dx_nxt = 1'b0;
                end else if (hit2) begin
                    x_nxt  = FACE2;
                    dx_nxt = 1'b1;
                end else if (miss_l) begin
                    sc2_nxt   = score_p2 + 4'd1;
                    point_nxt = tick;
                end else if (miss_r) begin
                    sc1_nxt   = score_p1 + 4'd1;
                    point_nxt = tick;
                end else begin
                    x_nxt = step_x;
                end
                // Wall bounce is independent of the horizontal outcome.
                if (step_y < 0) begin
                    y_nxt  = '0;
                    dy_nxt = 1'b0;
                end else if (step_y > Y_MAX) begin
                    y_nxt  = Y_MAX;
                    dy_nxt = 1'b1;
                end else begin
                    y_nxt = step_y;
                end
            end
            GAME_OVER: begin
                if (p1_srv | p2_srv) begin
                    sc1_nxt = '0;
                    sc2_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            ball_x     <= 10'(P2_X - SIZE);
            ball_y     <= 9'(V_ACT / 2);
            dx         <= 1'b1;
            dy         <= 1'b0;
            score_p1   <= '0;
            score_p2   <= '0;
            point      <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            vsync_prev <= vsync;
            point      <= point_nxt;
            if (tick) begin
                ball_x    <= x_nxt[9:0];
                ball_y    <= y_nxt[8:0];
                dx        <= dx_nxt;
                dy        <= dy_nxt;
                score_p1  <= sc1_nxt;
                score_p2  <= sc2_nxt;
                game_over <= over_nxt;
            end
        end
    end

    assign unused_bits = ^{x_nxt[11:10], y_nxt[11:9]};

endmodule

// File: tb/tb_ball_ctrl.sv
// tb_ball_ctrl: directed and randomized frames against a rule-level model.
// The model tracks the game as plain integers and named modes.
module tb_ball_ctrl;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       p1_srv;
    logic       p2_srv;
    logic [8:0] p1_y;
    logic [8:0] p2_y;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic       point;
    logic       game_over;

    int ncmp = 0;
    int nfail = 0;

    int    mx, my, mvx, mvy, ms1, ms2;
    string mode;
    bit    mpt, mover;

    ball_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .vsync    (vsync),
        .p1_srv   (p1_srv),
        .p2_srv   (p2_srv),
        .p1_y     (p1_y),
        .p2_y     (p2_y),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .point    (point),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_x"}, 32'(ball_x), mx);
        chk({tag, "_y"}, 32'(ball_y), my);
        chk({tag, "_s1"}, 32'(score_p1), ms1);
        chk({tag, "_s2"}, 32'(score_p2), ms2);
        chk({tag, "_pt"}, 32'(point), 32'(mpt));
        chk({tag, "_go"}, 32'(game_over), 32'(mover));
    endtask

    function automatic bit ov(int px, int py);
        return mx < px + 8 && mx + 8 > px && my < py + 50 && my + 8 > py;
    endfunction

    function automatic logic [8:0] track(int off);
        int v;
        v = my - off;
        if (v < 0) v = 0;
        if (v > 511) v = 511;
        return 9'(v);
    endfunction

    task automatic model_reset();
        mx = 592; my = 240; mvx = -1; mvy = 1;
        ms1 = 0; ms2 = 0; mode = "serve2";
        mpt = 0; mover = 0;
    endtask

    task automatic model_tick();
        int py, nx, ny;
        bit one;
        mpt = 0;
        if (mode == "serve1" || mode == "serve2") begin
            one = (mode == "serve1");
            py = one ? int'(p1_y) : int'(p2_y);
            mx = one ? 48 : 592;
            my = py + 21;
            if (my < 0) my = 0;
            if (my > 472) my = 472;
            if (one ? p1_srv : p2_srv) begin
                mode = "play";
                mvx = one ? 1 : -1;
                mvy = 1;
            end
        end else if (mode == "play") begin
            ny = my + 4 * mvy;
            if (mvx < 0 && ov(40, int'(p1_y))) begin
                mx = 48; mvx = 1;
            end else if (mvx > 0 && ov(600, int'(p2_y))) begin
                mx = 592; mvx = -1;
            end else begin
                nx = mx + 8 * mvx;
                if (nx < 0) begin
                    ms2++; mpt = 1;
                    if (ms2 == 9) mode = "over";
                    else mode = "serve1";
                end else if (nx + 8 > 640) begin
                    ms1++; mpt = 1;
                    if (ms1 == 9) mode = "over";
                    else mode = "serve2";
                end else begin
                    mx = nx;
                end
            end
            if (ny < 0) begin
                my = 0; mvy = 1;
            end else if (ny > 472) begin
                my = 472; mvy = -1;
            end else begin
                my = ny;
            end
        end else begin
            if (p1_srv || p2_srv) begin
                ms1 = 0; ms2 = 0; mode = "serve2";
            end
        end
        mover = (mode == "over");
    endtask

    // Inputs wiggle on the non-tick edge; only the tick-edge values count.
    task automatic do_tick(string tag);
        logic a, b;
        logic [8:0] ya, yb;
        a = p1_srv; b = p2_srv; ya = p1_y; yb = p2_y;
        vsync = 1'b1;
        p1_srv = 1'($urandom);
        p2_srv = 1'($urandom);
        p1_y = 9'($urandom);
        p2_y = 9'($urandom);
        @(posedge clk); #1;
        p1_srv = a; p2_srv = b; p1_y = ya; p2_y = yb;
        vsync = 1'b0;
        @(posedge clk); #1;
        model_tick();
        check_all(tag);
        @(posedge clk); #1;
        chk({tag, "_ptclr"}, 32'(point), 0);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1;
        p1_srv = 1'b0; p2_srv = 1'b0;
        p1_y = 9'd0; p2_y = 9'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; vsync = 1'b0;
        model_reset();
        check_all("reset");
        @(posedge clk); #1;
        check_all("no_tick_after_reset");

        for (int i = 0; i < 3; i++) do_tick("idle");
        chk("park_x", 32'(ball_x), 592);
        chk("park_y", 32'(ball_y), 121);

        p2_srv = 1'b1;
        do_tick("serve");
        p2_srv = 1'b0;
        do_tick("play1");
        chk("first_step_x", 32'(ball_x), 584);
        chk("first_step_y", 32'(ball_y), 125);
        for (int i = 0; i < 3; i++) do_tick("play");

        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all("rst_mid");

        for (int i = 0; i < 1200; i++) begin
            if (mode == "serve1") p1_srv = ($urandom_range(0, 2) == 0);
            else p1_srv = ($urandom_range(0, 7) == 0);
            if (mode == "serve2") p2_srv = ($urandom_range(0, 2) == 0);
            else p2_srv = ($urandom_range(0, 7) == 0);
            p1_y = ($urandom_range(0, 3) != 0)
                 ? track($urandom_range(0, 40)) : 9'($urandom);
            p2_y = ($urandom_range(0, 3) != 0)
                 ? track($urandom_range(0, 40)) : 9'($urandom);
            do_tick("rand");
        end

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all("reset2");
        p1_srv = 1'b0; p2_srv = 1'b0;
        for (int i = 0; i < 3000 && mode != "over"; i++) begin
            p2_srv = (mode == "serve2");
            p1_y = track(20);
            p2_y = 9'd511;
            do_tick("to_win");
        end
        chk("reach_over", 32'(game_over), 1);
        chk("win_score", 32'(score_p1), 9);
        p1_srv = 1'b0; p2_srv = 1'b0;
        for (int i = 0; i < 3; i++) do_tick("frozen");
        p1_srv = 1'b1;
        do_tick("restart");
        p1_srv = 1'b0;
        chk("restart_go", 32'(game_over), 0);
        for (int i = 0; i < 2; i++) do_tick("after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
